// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load, one-shot or auto-reload modes,
// and a registered one-cycle done pulse on expiry.
module countdown_timer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VALUE = 250
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             periodic_i,
  input  logic             cancel_i,
  output logic [WIDTH-1:0] count,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             periodic;
  logic [WIDTH-1:0] load_clamped;

  always_comb begin
    load_clamped = (load_value_i > MAX_V) ? MAX_V : load_value_i;
  end

  assign load_ready_o = (state == IDLE);
  assign busy_o       = (state == RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      reload   <= '0;
      periodic <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid_i) begin
            // A zero load expires immediately without ever entering RUN.
            if (load_clamped == '0) begin
              done_o <= 1'b1;
            end else begin
              count    <= load_clamped;
              reload   <= load_clamped;
              periodic <= periodic_i;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (cancel_i) begin
            count <= '0;
            state <= IDLE;
          end else if (enable_i) begin
            if (count > ONE) begin
              count <= count - ONE;
            end else begin
              done_o <= 1'b1;
              if (periodic) begin
                count <= reload;
              end else begin
                count <= '0;
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: an elapsed-edge model checked every cycle
// plus hand-computed literal expectations at the interesting points.
module tb_countdown_timer;

  localparam int WIDTH     = 8;
  localparam int MAX_VALUE = 250;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable_i = 1'b0;
  logic             load_valid_i = 1'b0;
  logic             load_ready_o;
  logic [WIDTH-1:0] load_value_i = '0;
  logic             periodic_i = 1'b0;
  logic             cancel_i = 1'b0;
  logic [WIDTH-1:0] count;
  logic             busy_o;
  logic             done_o;

  countdown_timer #(.WIDTH(WIDTH), .MAX_VALUE(MAX_VALUE)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable_i     (enable_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_value_i (load_value_i),
    .periodic_i   (periodic_i),
    .cancel_i     (cancel_i),
    .count        (count),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a run is described by its period and how many enabled edges have
  // elapsed; the remaining count is simply period - elapsed.
  int m_period, m_elapsed;
  bit m_run, m_per, m_done;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_per = 0; m_done = 0; m_period = 0; m_elapsed = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (load_valid_i) begin
          int v;
          v = (int'(load_value_i) > MAX_VALUE) ? MAX_VALUE : int'(load_value_i);
          if (v == 0) m_done = 1;
          else begin
            m_period = v; m_elapsed = 0; m_per = periodic_i; m_run = 1;
          end
        end
      end else if (cancel_i) begin
        m_run = 0;
      end else if (enable_i) begin
        m_elapsed++;
        if (m_elapsed == m_period) begin
          m_done = 1;
          if (m_per) m_elapsed = 0;
          else m_run = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_count", int'(count), m_run ? (m_period - m_elapsed) : 0);
      check("model_busy",  int'(busy_o), int'(m_run));
      check("model_ready", int'(load_ready_o), int'(!m_run));
      check("model_done",  int'(done_o), int'(m_done));
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic load(input int value, input bit per);
    load_valid_i = 1'b1;
    load_value_i = WIDTH'(value);
    periodic_i   = per;
    tick();
    load_valid_i = 1'b0;
  endtask

  // Counts negedges until done_o is seen, bounded by limit.
  task automatic wait_done(output int edges, input int limit);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!done_o && edges < limit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    tick(2);
    check("rst_count", int'(count), 0);
    check("rst_busy",  int'(busy_o), 0);
    check("rst_ready", int'(load_ready_o), 1);
    check("rst_done",  int'(done_o), 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    tick();

    // One-shot load of 5.
    enable_i = 1'b1;
    load(5, 1'b0);
    check("os_load_count", int'(count), 5);
    check("os_load_busy",  int'(busy_o), 1);
    tick(4);
    check("os_count1", int'(count), 1);
    tick();
    check("os_expire_count", int'(count), 0);
    check("os_expire_done",  int'(done_o), 1);
    tick();
    check("os_after_done",  int'(done_o), 0);
    check("os_after_ready", int'(load_ready_o), 1);

    // Clamp to MAX_VALUE.
    load(255, 1'b0);
    check("clamp_count", int'(count), 250);
    wait_done(edges, 300);
    check("clamp_latency", edges, 250);

    // Zero load.
    tick();
    load(0, 1'b0);
    check("zero_done", int'(done_o), 1);
    check("zero_busy", int'(busy_o), 0);
    tick();

    // Periodic load of 3, then cancel at count 2.
    load(3, 1'b1);
    check("per_load", int'(count), 3);
    tick(2);
    check("per_c1", int'(count), 1);
    tick();
    check("per_reload_count", int'(count), 3);
    check("per_reload_done",  int'(done_o), 1);
    check("per_reload_busy",  int'(busy_o), 1);
    tick(3);
    check("per_reload2_done", int'(done_o), 1);
    tick();
    check("per_c2", int'(count), 2);
    cancel_i = 1'b1;
    tick();
    cancel_i = 1'b0;
    check("cancel_count", int'(count), 0);
    check("cancel_busy",  int'(busy_o), 0);
    check("cancel_done",  int'(done_o), 0);
    periodic_i = 1'b0;
    tick();

    // Load 10, pause 4 cycles at 7, pending load of 4 held through the run.
    load(10, 1'b0);
    load_valid_i = 1'b1;
    load_value_i = 8'd4;
    periodic_i   = 1'b0;
    tick(3);
    check("pause_at7", int'(count), 7);
    enable_i = 1'b0;
    tick(4);
    check("pause_hold", int'(count), 7);
    check("pause_ready", int'(load_ready_o), 0);
    enable_i = 1'b1;
    wait_done(edges, 40);
    check("pause_latency", edges + 7, 14);
    tick();
    load_valid_i = 1'b0;
    check("pending_load", int'(count), 4);
    tick(3);
    check("pending_c1", int'(count), 1);

    // Cancel and enable together at count 1.
    cancel_i = 1'b1;
    tick();
    cancel_i = 1'b0;
    check("cancel_c1_count", int'(count), 0);
    check("cancel_c1_done",  int'(done_o), 0);
    check("cancel_c1_busy",  int'(busy_o), 0);
    tick();

    // Asynchronous reset mid-run at count 100.
    load(200, 1'b0);
    tick(100);
    check("pre_rst_count", int'(count), 100);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_busy",  int'(busy_o), 0);
    check("async_rst_ready", int'(load_ready_o), 1);
    tick();
    reset_n = 1'b1;
    tick(3);
    check("post_rst_count", int'(count), 0);
    check("post_rst_busy",  int'(busy_o), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter that complements the up-counting `counter` block.
- Accepts a start value over a valid/ready load handshake and decrements it once per enabled clock.
- Emits a one-cycle `done_o` pulse when the count expires.
- Supports one-shot and periodic (auto-reload) modes; used for timeouts, delays and tick generation beside the existing up-counter.

Parameters:
- WIDTH, 8, bit width of the count and load value.
- MAX_VALUE, 250, largest accepted load value; larger loads clamp to MAX_VALUE. Must be < 2**WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable_i  input  1  decrement qualifier; count holds while low.
- load_valid_i  input  1  load request.
- load_ready_o  output  1  high when a load can be accepted (IDLE only).
- load_value_i  input  WIDTH  start value, sampled when load_valid_i && load_ready_o.
- periodic_i  input  1  mode, sampled with the load: 1 = auto-reload, 0 = one-shot.
- cancel_i  input  1  abort the running count.
- count  output  WIDTH  current remaining count.
- busy_o  output  1  high in RUN.
- done_o  output  1  registered one-cycle expiry pulse.

Behaviour:
- Reset:
  - Asynchronous, active-low: reset_n low immediately forces state IDLE.
  - count=0, reload register=0, mode=one-shot, busy_o=0, done_o=0, load_ready_o=1.
  - Applies at any time, including mid-RUN; no done pulse results.
- States: IDLE, RUN. load_ready_o = (state==IDLE); busy_o = (state==RUN). Both are combinational from registered state.
- IDLE, on load handshake:
  - v = min(load_value_i, MAX_VALUE), using an unsigned compare.
  - If v==0: count stays 0, state stays IDLE, done_o=1 on that edge.
  - Else: count<=v, reload<=v, mode<=periodic_i, state<=RUN on that edge.
- cancel_i and enable_i are ignored in IDLE.
- RUN, priority order per edge:
  1. cancel_i=1: count<=0, state<=IDLE, done_o stays 0. Cancel wins over expiry in the same cycle.
  2. enable_i=0: count holds, done_o=0.
  3. enable_i=1 and count>1: count<=count-1.
  4. enable_i=1 and count==1 (expiry), done_o<=1 on that edge:
     - One-shot: count<=0, state<=IDLE.
     - Periodic: count<=reload, state stays RUN.
- done_o is 0 on every edge not listed above.
- Latency: done_o asserts on exactly the v-th enabled edge after the load edge. A periodic period is exactly reload enabled cycles.
- Count never goes below 0 and never exceeds MAX_VALUE.
- Handshake:
  - Loads are refused while RUN (load_ready_o=0); the requester holds load_valid_i until accepted.
  - A load pending at one-shot expiry is accepted on the next edge (ready rises after expiry).
  - A new load in IDLE immediately after expiry is legal; done_o and the new count may be high on consecutive edges.
- load_value_i and periodic_i are don't-care when not handshaking.

Test Plan:
- Reset, then one-shot load 5 with enable_i=1 -> count 5,4,3,2,1,0 on successive edges; done_o high for exactly the edge count reaches 0; busy_o then 0, load_ready_o 1.
- Load 255 with MAX_VALUE=250 -> count 250 after load, done_o on the 250th enabled edge; load 0 -> done_o pulse next edge, busy_o stays 0.
- Periodic load 3 -> count 3,2,1,3,2,1,3; done_o on each reload edge (every 3 cycles); cancel_i at count 2 -> count 0, IDLE, no done_o.
- Load 10, drop enable_i for 4 cycles at count 7 -> count holds 7; done_o arrives 14 edges after load. Hold load_valid_i with value 4 during RUN -> not accepted until the edge after expiry, then count 4.
- cancel_i and enable_i both high at count 1 -> count 0, no done_o.
- At count 100, drive reset_n low between edges -> count 0, busy_o 0, load_ready_o 1 before the next clock edge. Release reset_n -> stays IDLE and 0.
